y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares one byte-wide, single-port memory between the y86 CPU instruction-fetch port and its data read/write port.
- Arbitrates round-robin between the two ports and sequences each 32-bit access as four little-endian byte beats.
- Returns each assembled word with a one-cycle acknowledge.
- Sits between cisc_cpu_p bus pins and the memory model/SRAM.

Parameters:
AW, 32, address width of all address ports (byte addresses).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
ins_req  in  1  instruction read request, held until ins_ack
ins_addr  in  AW  instruction byte address, stable while ins_req
ins_rdata  out  32  fetched word, valid in ins_ack cycle, held until next ins_ack
ins_ack  out  1  one-cycle completion pulse
dat_req  in  1  data request, held until dat_ack
dat_we  in  1  1=write, 0=read; stable while dat_req
dat_addr  in  AW  data byte address
dat_wdata  in  32  write word
dat_rdata  out  32  read word, valid in dat_ack cycle, held until next read dat_ack
dat_ack  out  1  one-cycle completion pulse
mem_addr  out  AW  byte address of current beat
mem_re  out  1  byte read strobe
mem_we  out  1  byte write strobe
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, valid in cycle after beat acceptance
mem_wait  in  1  stall; a beat is accepted at a clk edge with (mem_re|mem_we)=1 and mem_wait=0
busy  out  1  high in any state other than IDLE
grant_dat  out  1  owner of current/last transaction: 1=data, 0=instruction

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0; FSM to IDLE; last-grant = dat, so instruction wins first tie. Reset mid-transaction abandons it with no ack. Bytes already written stay written.
- FSM: IDLE -> XFER -> (DRAIN if read) -> ACK -> IDLE.
- IDLE: samples requests.
  - Exactly one req: grant it.
  - Both: grant the port not granted last.
  - On grant: latch addr, we, wdata; beat counter = 0; go XFER.
- XFER:
  - Drives beat i: mem_addr = addr+i modulo 2^AW (no alignment requirement).
  - Write: mem_we=1, mem_wdata = wdata[8i+7:8i]. Read: mem_re=1.
  - mem_wait=1: all mem outputs held, counter frozen.
  - On acceptance of beat 3: go DRAIN (read) or ACK (write).
- Read capture: the byte of the beat accepted at edge t is captured at edge t+1 into bits [8i+7:8i], independent of mem_wait. Beat 3's byte is captured at the end of DRAIN.
- ACK (one cycle): granted port's ack=1; rdata updated (reads only); strobes 0; next state IDLE.
  - The ACK cycle never samples requests.
  - A req still high in the following IDLE cycle is a new transaction.
- Latency, zero wait states, req high in cycle 0:
  - Read: beats in cycles 1–4, DRAIN in cycle 5, ack in cycle 6.
  - Write: beats in cycles 1–4, ack in cycle 5.
  - Each wait cycle adds one.
- Non-granted port: req ignored until the next IDLE; its ack stays 0.
- dat_rdata is unchanged by writes. The ins side never writes.
- A request input changing while not yet granted is legal and carries no meaning.

Decomposition:
- Package y86_mem_pkg:
  - state enum {IDLE, XFER, DRAIN, ACK}
  - BEATS=4
  - GRANT_INS=0 / GRANT_DAT=1 constants
- Sub-module y86_rr_arb2: 2-requester round-robin with last-grant register and an update strobe asserted on grant.

Test Plan:
- Memory bytes 0x17..0x1A = 01 00 00 00; ins_req, ins_addr=0x17, no waits -> mem_re at 0x17..0x1A in cycles 1–4; ins_ack in cycle 6; ins_rdata=0x00000001.
- dat write 0x0000000A to 0x1B, then dat read 0x1B -> write: bytes 0A,00,00,00 at 0x1B..0x1E, dat_ack in cycle 5. Read: dat_rdata=0x0000000A, ins_ack never asserted.
- ins_req and dat_req (read) both high from the cycle after reset -> grants alternate ins, dat, ins, dat; grant_dat = 0,1,0,1; no port is starved.
- Read at 0x20 with mem_wait=1 on beats 1 and 3 for 2 cycles each -> mem outputs held during stalls; ack in cycle 10; word correct.
- Read at addr 0xFFFFFFFE -> beats at FFFFFFFE, FFFFFFFF, 00000000, 00000001; word assembled in that byte order.
- rst=0 after beat 1 of a write of 0xAABBCCDD to 0x40 -> next cycle all outputs 0, busy=0, no dat_ack. Memory holds DD,CC at 0x40/0x41; 0x42/0x43 unchanged.

Source files
------------

// File: rtl/y86_mem_arbiter_pkg.sv
// Shared types and constants for the y86 instruction/data memory arbiter.
// The arbiter moves each 32-bit word as four byte beats on a byte-wide memory.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        ACK
    } state_t;

    localparam int   BEATS     = 4;
    localparam logic GRANT_INS = 1'b0;
    localparam logic GRANT_DAT = 1'b1;

    // Byte i of a little-endian word
    function automatic logic [7:0] beat_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bus bundle between the y86 CPU fetch/data pins, the arbiter and the byte memory.
// The slave view belongs to the arbiter; the master view belongs to the CPU and memory side.
interface y86_mem_arbiter_if #(parameter int AW = 32);

    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic [31:0]   ins_rdata;
    logic          ins_ack;

    logic          dat_req;
    logic          dat_we;
    logic [AW-1:0] dat_addr;
    logic [31:0]   dat_wdata;
    logic [31:0]   dat_rdata;
    logic          dat_ack;

    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_wait;

    logic          busy;
    logic          grant_dat;

    modport slave (
        input  ins_req, ins_addr,
        input  dat_req, dat_we, dat_addr, dat_wdata,
        input  mem_rdata, mem_wait,
        output ins_rdata, ins_ack,
        output dat_rdata, dat_ack,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output busy, grant_dat
    );

    modport master (
        output ins_req, ins_addr,
        output dat_req, dat_we, dat_addr, dat_wdata,
        output mem_rdata, mem_wait,
        input  ins_rdata, ins_ack,
        input  dat_rdata, dat_ack,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  busy, grant_dat
    );

endinterface

// File: rtl/y86_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the port not granted last wins.
// The last-grant register only moves when the owner accepts the grant via update.
module y86_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_ins,
    input  logic req_dat,
    input  logic update,
    output logic valid,
    output logic grant_dat
);
    import y86_mem_pkg::*;

    logic last_dat;

    always_comb begin
        valid     = req_ins | req_dat;
        grant_dat = GRANT_INS;
        if (req_ins && req_dat) begin
            grant_dat = ~last_dat;
        end else if (req_dat) begin
            grant_dat = GRANT_DAT;
        end
    end

    // Reset to "data granted last" so the instruction port wins the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_dat <= GRANT_DAT;
        end else if (update) begin
            last_dat <= grant_dat;
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares a byte-wide single-port memory between the y86 fetch and data ports,
// sequencing each 32-bit access as four little-endian byte beats.
module y86_mem_arbiter #(
    parameter int AW = 32
) (
    input  logic             clk,
    input  logic             rst,
    y86_mem_arbiter_if.slave bus
);
    import y86_mem_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    beat;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic          owner;
    logic [23:0]   rd_asm;
    logic          cap_pend;
    logic [1:0]    cap_idx;
    logic [31:0]   ins_rdata_q;
    logic [31:0]   dat_rdata_q;

    logic arb_valid;
    logic arb_grant_dat;
    logic grant_now;
    logic beat_acc;
    logic last_beat;

    assign grant_now = (state == IDLE) && arb_valid;
    assign beat_acc  = (state == XFER) && !bus.mem_wait;
    assign last_beat = (beat == 2'(BEATS - 1));

    y86_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_ins   (bus.ins_req),
        .req_dat   (bus.dat_req),
        .update    (grant_now),
        .valid     (arb_valid),
        .grant_dat (arb_grant_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reads need one extra cycle after the last beat for its byte to arrive
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = XFER;
            XFER:    if (beat_acc && last_beat) state_nxt = we_q ? ACK : DRAIN;
            DRAIN:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each accepted read beat returns its byte one edge later, whatever mem_wait does then
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat        <= 2'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            owner       <= GRANT_INS;
            rd_asm      <= 24'h0;
            cap_pend    <= 1'b0;
            cap_idx     <= 2'd0;
            ins_rdata_q <= 32'h0;
            dat_rdata_q <= 32'h0;
        end else begin
            if (grant_now) begin
                addr_q  <= arb_grant_dat ? bus.dat_addr : bus.ins_addr;
                we_q    <= arb_grant_dat & bus.dat_we;
                wdata_q <= bus.dat_wdata;
                owner   <= arb_grant_dat;
                beat    <= 2'd0;
            end else if (beat_acc) begin
                beat <= beat + 2'd1;
            end

            cap_pend <= beat_acc && !we_q;
            cap_idx  <= beat;
            if (cap_pend) begin
                case (cap_idx)
                    2'd0:    rd_asm[7:0]   <= bus.mem_rdata;
                    2'd1:    rd_asm[15:8]  <= bus.mem_rdata;
                    2'd2:    rd_asm[23:16] <= bus.mem_rdata;
                    default: ;
                endcase
            end

            if (state == DRAIN) begin
                if (owner == GRANT_DAT) begin
                    dat_rdata_q <= {bus.mem_rdata, rd_asm};
                end else begin
                    ins_rdata_q <= {bus.mem_rdata, rd_asm};
                end
            end
        end
    end

    // Memory outputs derive only from registered state, so a stall holds them naturally
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 8'h00;
        bus.ins_ack   = 1'b0;
        bus.dat_ack   = 1'b0;
        case (state)
            XFER: begin
                bus.mem_addr  = addr_q + AW'(beat);
                bus.mem_re    = ~we_q;
                bus.mem_we    = we_q;
                bus.mem_wdata = we_q ? beat_byte(wdata_q, beat) : 8'h00;
            end
            ACK: begin
                bus.ins_ack = (owner == GRANT_INS);
                bus.dat_ack = (owner == GRANT_DAT);
            end
            default: ;
        endcase
        bus.busy      = (state != IDLE);
        bus.grant_dat = owner;
        bus.ins_rdata = ins_rdata_q;
        bus.dat_rdata = dat_rdata_q;
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Self-checking bench for y86_mem_arbiter: a byte memory model with stall injection,
// a table of single transactions, and hand-written round-robin and reset sequences.
module tb_y86_mem_arbiter;
    import y86_mem_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    y86_mem_arbiter_if #(.AW(AW)) bus ();

    y86_mem_arbiter #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_dat;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  stall;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs [10];
    exp_t        sb_q [$];
    exp_t        sb_e;
    logic [32:0] beat_log [$];
    logic [7:0]  mem [256];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_dat_rd;
    logic        ack_now;
    logic [3:0]  stall_mask;
    logic [3:0]  stall_done;
    int          stall_cnt;
    logic [31:0] cur_base;
    logic [41:0] snap;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_output({name, "_rdata"}, {bus.ins_rdata, bus.dat_rdata}, 64'h0);
        check_output({name, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
        check_output({name, "_ctrl"},
                     {bus.ins_ack, bus.dat_ack, bus.mem_re, bus.mem_we, bus.mem_wdata, bus.busy, bus.grant_dat},
                     64'h0);
    endtask

    // One clock: memory acceptance on the rising edge, checks and stall drive on the falling edge
    task automatic tick();
        logic [1:0] idx;
        @(posedge clk);
        if ((bus.mem_re || bus.mem_we) && bus.mem_wait === 1'b0) begin
            beat_log.push_back({bus.mem_we, bus.mem_addr});
            if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
        @(negedge clk);
        if (bus.mem_wait) begin
            check_output("stall_hold", {bus.mem_re, bus.mem_we, bus.mem_wdata, bus.mem_addr}, snap);
        end
        ack_now = bus.ins_ack | bus.dat_ack;
        if (ack_now) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_ack", {bus.ins_ack, bus.dat_ack}, 64'h0);
            end else begin
                sb_e = sb_q.pop_front();
                check_output("ack_port", {bus.ins_ack, bus.dat_ack}, sb_e.port ? 64'h1 : 64'h2);
                check_output("grant_dat", bus.grant_dat, sb_e.port);
                check_output("rdata", sb_e.port ? bus.dat_rdata : bus.ins_rdata, sb_e.data);
            end
        end
        bus.mem_wait = 1'b0;
        if (bus.mem_re || bus.mem_we) begin
            idx = 2'(bus.mem_addr - cur_base);
            if (stall_mask[idx] && !stall_done[idx]) begin
                if (stall_cnt < 2) begin
                    bus.mem_wait = 1'b1;
                    stall_cnt++;
                    snap = {bus.mem_re, bus.mem_we, bus.mem_wdata, bus.mem_addr};
                end else begin
                    stall_done[idx] = 1'b1;
                    stall_cnt = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ins_req = 1'b0;
        bus.dat_req = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        last_dat_rd = 32'h0;
        stall_mask = 4'b0;
        sb_q.delete();
    endtask

    task automatic apply_stimulus(input vec_t v);
        int cyc;
        int base;
        stall_mask = v.stall;
        stall_done = 4'b0;
        stall_cnt  = 0;
        cur_base   = v.addr;
        base       = beat_log.size();
        sb_q.push_back('{port: v.is_dat, data: v.we ? last_dat_rd : v.exp_word});
        if (v.is_dat && !v.we) last_dat_rd = v.exp_word;
        if (v.is_dat) begin
            bus.dat_req   = 1'b1;
            bus.dat_we    = v.we;
            bus.dat_addr  = v.addr;
            bus.dat_wdata = v.wdata;
        end else begin
            bus.ins_req  = 1'b1;
            bus.ins_addr = v.addr;
        end
        cyc = 0;
        ack_now = 1'b0;
        while (!ack_now && cyc < 40) begin
            tick();
            cyc++;
        end
        check_output("latency", cyc, v.exp_lat);
        bus.ins_req = 1'b0;
        bus.dat_req = 1'b0;
        check_output("beat_count", beat_log.size() - base, BEATS);
        for (int i = 0; i < BEATS && base + i < beat_log.size(); i++) begin
            check_output("beat_addr", beat_log[base + i], {v.we, 32'(v.addr + 32'(i))});
        end
        tick();
    endtask

    initial begin
        int n;
        bus.ins_req   = 1'b0;
        bus.ins_addr  = '0;
        bus.dat_req   = 1'b0;
        bus.dat_we    = 1'b0;
        bus.dat_addr  = '0;
        bus.dat_wdata = 32'h0;
        bus.mem_wait  = 1'b0;
        cur_base      = 32'h0;
        stall_done    = 4'b0;
        stall_cnt     = 0;
        snap          = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h17] = 8'h01;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
        mem[8'h40] = 8'h55; mem[8'h41] = 8'h55; mem[8'h42] = 8'h55; mem[8'h43] = 8'h55;

        //            is_dat we    addr          wdata         stall    exp_word      lat
        vecs[0] = '{1'b0, 1'b0, 32'h00000017, 32'h0,        4'b0000, 32'h00000001, 6};
        vecs[1] = '{1'b1, 1'b1, 32'h0000001B, 32'h0000000A, 4'b0000, 32'h0,        5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000001B, 32'h0,        4'b0000, 32'h0000000A, 6};
        vecs[3] = '{1'b1, 1'b0, 32'h00000020, 32'h0,        4'b1010, 32'h44332211, 10};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFE, 32'h0,        4'b0000, 32'hD4C3B2A1, 6};
        vecs[5] = '{1'b1, 1'b1, 32'h00000030, 32'hDEADBEEF, 4'b0000, 32'h0,        5};
        vecs[6] = '{1'b0, 1'b0, 32'h00000030, 32'h0,        4'b0000, 32'hDEADBEEF, 6};
        vecs[7] = '{1'b1, 1'b1, 32'h00000021, 32'h01020304, 4'b0101, 32'h0,        9};
        vecs[8] = '{1'b1, 1'b0, 32'h00000020, 32'h0,        4'b0000, 32'h02030411, 6};
        vecs[9] = '{1'b1, 1'b0, 32'h00000031, 32'h0,        4'b0000, 32'h00DEADBE, 6};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
        end
        check_output("mem_1b_1e", {mem[8'h1E], mem[8'h1D], mem[8'h1C], mem[8'h1B]}, 64'h0000000A);

        // Both ports requesting continuously: grants must alternate starting with ins
        do_reset();
        cur_base = 32'h0;
        sb_q.push_back('{port: 1'b0, data: 32'h00000001});
        sb_q.push_back('{port: 1'b1, data: 32'h0000000A});
        sb_q.push_back('{port: 1'b0, data: 32'h00000001});
        sb_q.push_back('{port: 1'b1, data: 32'h0000000A});
        bus.ins_req  = 1'b1;
        bus.ins_addr = 32'h17;
        bus.dat_req  = 1'b1;
        bus.dat_we   = 1'b0;
        bus.dat_addr = 32'h1B;
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            tick();
            if (ack_now) n++;
        end
        bus.ins_req = 1'b0;
        bus.dat_req = 1'b0;
        check_output("rr_ack_count", n, 4);
        tick();

        // Reset while beat 1 of a write is on the bus: two bytes land, no ack follows
        do_reset();
        bus.dat_req   = 1'b1;
        bus.dat_we    = 1'b1;
        bus.dat_addr  = 32'h40;
        bus.dat_wdata = 32'hAABBCCDD;
        n = 0;
        while (!(bus.mem_we && bus.mem_addr == 32'h41) && n < 20) begin
            tick();
            n++;
        end
        check_output("reach_beat1", n, 2);
        rst = 1'b0;
        bus.dat_req = 1'b0;
        tick();
        check_idle_outputs("midreset");
        rst = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check_output("mem_40", mem[8'h40], 8'hDD);
        check_output("mem_41", mem[8'h41], 8'hCC);
        check_output("mem_42", mem[8'h42], 8'h55);
        check_output("mem_43", mem[8'h43], 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
